// File: rtl/probe_burst_tx.sv
`default_nettype none
// ============================================================================
//  Module   : probe_burst_tx
//  Purpose  : Transmit side of the speed-of-sound ranging loop. On trigger,
//             emits a square-wave probe burst of BURST_LEN samples on the
//             speaker stream (one sample per step_in), then holds a silent
//             guard interval of GUARD_LEN steps before accepting a new
//             trigger. Marks burst start/end with sample-accurate pulses.
//  Ports    : clk_in          system clock
//             rst_in_n        asynchronous active-low reset
//             step_in         one-clk pulse per 24 kHz sample period
//             trigger         one-clk burst request
//             abort           one-clk kill request (burst -> silent guard)
//             amp_out         signed 16-bit speaker sample (registered)
//             busy            high in every state except IDLE
//             tx_start        pulse on the clk amp_out takes the first sample
//             tx_done         pulse on the clk amp_out returns to 0 at the end
//             aborted         pulse when an abort is accepted
//             trigger_dropped pulse when a trigger is ignored
//  Revision : 1.0  initial release
// ============================================================================
module probe_burst_tx #(
    parameter int                 BURST_LEN   = 8,
    parameter int                 HALF_PERIOD = 2,
    parameter logic signed [15:0] AMPLITUDE   = 16'sd12000,
    parameter int                 GUARD_LEN   = 64
) (
    input  logic               clk_in,
    input  logic               rst_in_n,
    input  logic               step_in,
    input  logic               trigger,
    input  logic               abort,
    output logic signed [15:0] amp_out,
    output logic               busy,
    output logic               tx_start,
    output logic               tx_done,
    output logic               aborted,
    output logic               trigger_dropped
);

    localparam int SIX_W = $clog2(BURST_LEN + 1);
    localparam int GIX_W = (GUARD_LEN > 0) ? $clog2(GUARD_LEN + 1) : 1;

    localparam logic [SIX_W-1:0]        SIX_LAST   = SIX_W'(BURST_LEN);
    localparam logic [GIX_W-1:0]        GUARD_LAST = GIX_W'((GUARD_LEN > 0) ? GUARD_LEN - 1 : 0);
    localparam logic signed [15:0]      NEG_AMP    = -AMPLITUDE;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        BURST = 2'd2,
        GUARD = 2'd3
    } state_t;

    state_t           state;
    logic [SIX_W-1:0] sample_ix;
    logic [GIX_W-1:0] guard_ix;
    logic             neg_half;

    // Sample k is negative when floor(k / HALF_PERIOD) is odd. Done at 32 bits
    // so a HALF_PERIOD wider than the sample counter cannot truncate to zero.
    assign neg_half = ((32'(sample_ix) / 32'(HALF_PERIOD)) % 32'd2) != 32'd0;

    always_ff @(posedge clk_in or negedge rst_in_n) begin
        if (!rst_in_n) begin
            state           <= IDLE;
            amp_out         <= 16'sd0;
            busy            <= 1'b0;
            tx_start        <= 1'b0;
            tx_done         <= 1'b0;
            aborted         <= 1'b0;
            trigger_dropped <= 1'b0;
            sample_ix       <= '0;
            guard_ix        <= '0;
        end else begin
            tx_start        <= 1'b0;
            tx_done         <= 1'b0;
            aborted         <= 1'b0;
            trigger_dropped <= 1'b0;

            // Any trigger outside IDLE is refused, whatever else happens.
            if (state != IDLE && trigger) begin
                trigger_dropped <= 1'b1;
            end

            case (state)
                IDLE: begin
                    amp_out <= 16'sd0;
                    if (trigger) begin
                        if (abort) begin
                            trigger_dropped <= 1'b1;
                        end else begin
                            state <= ARMED;
                            busy  <= 1'b1;
                        end
                    end
                end

                ARMED, BURST: begin
                    if (abort) begin
                        // Abort wins over a coincident step: no sample, no
                        // tx_start/tx_done.
                        amp_out   <= 16'sd0;
                        aborted   <= 1'b1;
                        sample_ix <= '0;
                        guard_ix  <= '0;
                        if (GUARD_LEN == 0) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else begin
                            state <= GUARD;
                        end
                    end else if (step_in) begin
                        if (state == ARMED) begin
                            amp_out   <= AMPLITUDE;
                            tx_start  <= 1'b1;
                            sample_ix <= SIX_W'(1);
                            state     <= BURST;
                        end else if (sample_ix == SIX_LAST) begin
                            amp_out   <= 16'sd0;
                            tx_done   <= 1'b1;
                            sample_ix <= '0;
                            guard_ix  <= '0;
                            if (GUARD_LEN == 0) begin
                                state <= IDLE;
                                busy  <= 1'b0;
                            end else begin
                                state <= GUARD;
                            end
                        end else begin
                            amp_out   <= neg_half ? NEG_AMP : AMPLITUDE;
                            sample_ix <= sample_ix + SIX_W'(1);
                        end
                    end
                end

                GUARD: begin
                    amp_out <= 16'sd0;
                    if (abort) begin
                        // Restart the full guard interval.
                        aborted  <= 1'b1;
                        guard_ix <= '0;
                    end else if (step_in) begin
                        if (guard_ix == GUARD_LAST) begin
                            state    <= IDLE;
                            busy     <= 1'b0;
                            guard_ix <= '0;
                        end else begin
                            guard_ix <= guard_ix + GIX_W'(1);
                        end
                    end
                end

                default: begin
                    state   <= IDLE;
                    busy    <= 1'b0;
                    amp_out <= 16'sd0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_probe_burst_tx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_probe_burst_tx
//  Purpose  : Self-checking bench for probe_burst_tx. Three instances with
//             different parameter sets share clock, reset and step_in; each
//             has its own trigger/abort. Expected samples come from the
//             step-count timeline of a burst (step j emits sample j-1, step
//             BURST_LEN+1 ends the burst, GUARD_LEN further steps release).
//  Revision : 1.0  initial release
// ============================================================================
module tb_probe_burst_tx;

    localparam logic signed [15:0] AMP = 16'sd12000;

    logic               clk;
    logic               rst_n;
    logic               step;
    logic               trig   [3];
    logic               abrt   [3];
    logic signed [15:0] amp    [3];
    logic               busy   [3];
    logic               tx_start [3];
    logic               tx_done  [3];
    logic               aborted  [3];
    logic               dropped  [3];

    int checks = 0;
    int errors = 0;

    // d0: defaults with a short guard; d1: fastest alternation; d2: no guard
    probe_burst_tx #(.BURST_LEN(8), .HALF_PERIOD(2), .AMPLITUDE(AMP), .GUARD_LEN(4)) dut0 (
        .clk_in(clk), .rst_in_n(rst_n), .step_in(step), .trigger(trig[0]), .abort(abrt[0]),
        .amp_out(amp[0]), .busy(busy[0]), .tx_start(tx_start[0]), .tx_done(tx_done[0]),
        .aborted(aborted[0]), .trigger_dropped(dropped[0]));

    probe_burst_tx #(.BURST_LEN(3), .HALF_PERIOD(1), .AMPLITUDE(AMP), .GUARD_LEN(4)) dut1 (
        .clk_in(clk), .rst_in_n(rst_n), .step_in(step), .trigger(trig[1]), .abort(abrt[1]),
        .amp_out(amp[1]), .busy(busy[1]), .tx_start(tx_start[1]), .tx_done(tx_done[1]),
        .aborted(aborted[1]), .trigger_dropped(dropped[1]));

    probe_burst_tx #(.BURST_LEN(8), .HALF_PERIOD(2), .AMPLITUDE(AMP), .GUARD_LEN(0)) dut2 (
        .clk_in(clk), .rst_in_n(rst_n), .step_in(step), .trigger(trig[2]), .abort(abrt[2]),
        .amp_out(amp[2]), .busy(busy[2]), .tx_start(tx_start[2]), .tx_done(tx_done[2]),
        .aborted(aborted[2]), .trigger_dropped(dropped[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1);
    end

    // Square-wave sample k of a burst.
    function automatic logic signed [15:0] sample(input int k, input int hp);
        return (((k / hp) % 2) == 0) ? AMP : -AMP;
    endfunction

    // One clock: inputs set before the call are seen on this edge, then cleared.
    task automatic tick();
        @(posedge clk);
        #1;
        step = 1'b0;
        for (int i = 0; i < 3; i++) begin
            trig[i] = 1'b0;
            abrt[i] = 1'b0;
        end
    endtask

    task automatic test_reset();
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (amp[d] !== 16'sd0 || {busy[d], tx_start[d], tx_done[d], aborted[d], dropped[d]} !== 5'b0) begin
                errors++;
                $display("FAIL reset d%0d amp=%0d flags=%b expected amp=0 flags=00000", d, amp[d],
                         {busy[d], tx_start[d], tx_done[d], aborted[d], dropped[d]});
            end
        end
    endtask

    // Full burst with random gaps between steps; optional trigger noise while busy.
    task automatic run_burst(input int d, input int bl, input int hp, input int gl,
                             input bit same_step, input bit noise);
        logic signed [15:0] e;
        int last, gap;
        bit t;
        last = bl + 1 + gl;
        trig[d] = 1'b1;
        step = same_step;
        tick();
        checks++;
        if (amp[d] !== 16'sd0 || {tx_start[d], busy[d], dropped[d]} !== 3'b010) begin
            errors++;
            $display("FAIL arm d%0d amp=%0d start/busy/drop=%b expected amp=0 start/busy/drop=010",
                     d, amp[d], {tx_start[d], busy[d], dropped[d]});
        end
        e = 16'sd0;
        for (int j = 1; j <= last; j++) begin
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) begin
                t = noise && ($urandom_range(0, 1) == 1);
                trig[d] = t;
                tick();
                checks++;
                if (amp[d] !== e || {tx_start[d], tx_done[d], busy[d], dropped[d]} !== {3'b001, t}) begin
                    errors++;
                    $display("FAIL hold d%0d step%0d amp=%0d flags=%b expected amp=%0d flags=%b",
                             d, j, amp[d], {tx_start[d], tx_done[d], busy[d], dropped[d]}, e, {3'b001, t});
                end
            end
            t = noise && ($urandom_range(0, 1) == 1);
            trig[d] = t;
            step = 1'b1;
            tick();
            e = (j <= bl) ? sample(j - 1, hp) : 16'sd0;
            checks++;
            if (amp[d] !== e) begin
                errors++;
                $display("FAIL amp d%0d step%0d got %0d expected %0d", d, j, amp[d], e);
            end
            checks++;
            if ({tx_start[d], tx_done[d], busy[d], dropped[d]} !== {(j == 1), (j == bl + 1), (j < last), t}) begin
                errors++;
                $display("FAIL flags d%0d step%0d start/done/busy/drop=%b expected %b", d, j,
                         {tx_start[d], tx_done[d], busy[d], dropped[d]}, {(j == 1), (j == bl + 1), (j < last), t});
            end
        end
    endtask

    // Abort on dut0 after n samples (n=0 aborts from ARMED), optionally on a step clk,
    // or once in the guard interval; busy must then last exactly 4 more steps.
    task automatic test_abort(input bit coincident, input bit in_guard);
        int n;
        n = in_guard ? 10 : $urandom_range(0, 8);
        trig[0] = 1'b1;
        tick();
        for (int k = 0; k < n; k++) begin
            step = 1'b1;
            tick();
            checks++;
            if (amp[0] !== ((k < 8) ? sample(k, 2) : 16'sd0)) begin
                errors++;
                $display("FAIL pre_abort k%0d got %0d expected %0d", k, amp[0], (k < 8) ? sample(k, 2) : 16'sd0);
            end
        end
        abrt[0] = 1'b1;
        step = coincident;
        tick();
        checks++;
        if (amp[0] !== 16'sd0 || {tx_start[0], tx_done[0], busy[0], aborted[0]} !== 4'b0011) begin
            errors++;
            $display("FAIL abort n%0d amp=%0d start/done/busy/abrt=%b expected amp=0 flags=0011",
                     n, amp[0], {tx_start[0], tx_done[0], busy[0], aborted[0]});
        end
        for (int j = 1; j <= 4; j++) begin
            step = 1'b1;
            tick();
            checks++;
            if (amp[0] !== 16'sd0 || {tx_done[0], busy[0], aborted[0]} !== {1'b0, (j < 4), 1'b0}) begin
                errors++;
                $display("FAIL abort_guard j%0d amp=%0d done/busy/abrt=%b expected amp=0 flags=%b",
                         j, amp[0], {tx_done[0], busy[0], aborted[0]}, {1'b0, (j < 4), 1'b0});
            end
        end
    endtask

    task automatic test_idle_abort();
        abrt[0] = 1'b1;
        tick();
        checks++;
        if ({busy[0], aborted[0], dropped[0]} !== 3'b000) begin
            errors++;
            $display("FAIL idle_abort busy/abrt/drop=%b expected 000", {busy[0], aborted[0], dropped[0]});
        end
        abrt[0] = 1'b1;
        trig[0] = 1'b1;
        tick();
        checks++;
        if ({busy[0], aborted[0], dropped[0]} !== 3'b001) begin
            errors++;
            $display("FAIL trig_abort busy/abrt/drop=%b expected 001", {busy[0], aborted[0], dropped[0]});
        end
        step = 1'b1;
        tick();
        checks++;
        if ({busy[0], tx_start[0], dropped[0]} !== 3'b000 || amp[0] !== 16'sd0) begin
            errors++;
            $display("FAIL trig_abort_idle busy/start/drop=%b amp=%0d expected 000 amp=0",
                     {busy[0], tx_start[0], dropped[0]}, amp[0]);
        end
    endtask

    task automatic test_async_reset();
        trig[0] = 1'b1;
        tick();
        for (int k = 0; k < 3; k++) begin
            step = 1'b1;
            tick();
        end
        checks++;
        if (amp[0] !== -AMP) begin
            errors++;
            $display("FAIL pre_reset amp got %0d expected %0d", amp[0], -AMP);
        end
        #3 rst_n = 1'b0;
        #1;
        checks++;
        if (amp[0] !== 16'sd0 || busy[0] !== 1'b0) begin
            errors++;
            $display("FAIL async_reset amp=%0d busy=%b expected amp=0 busy=0", amp[0], busy[0]);
        end
        tick();
        rst_n = 1'b1;
        tick();
        run_burst(0, 8, 2, 4, 1'b0, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0;
        step  = 1'b0;
        for (int i = 0; i < 3; i++) begin
            trig[i] = 1'b0;
            abrt[i] = 1'b0;
        end
        repeat (3) tick();
        test_reset();
        rst_n = 1'b1;
        tick();

        run_burst(0, 8, 2, 4, 1'b0, 1'b0);
        run_burst(0, 8, 2, 4, 1'b0, 1'b1);
        run_burst(1, 3, 1, 4, 1'b1, 1'b0);
        run_burst(1, 3, 1, 4, 1'b0, 1'b1);
        for (int r = 0; r < 4; r++) test_abort(r[0], 1'b0);
        test_abort(1'b0, 1'b1);
        test_idle_abort();
        // Back-to-back with no guard: second trigger on the clk after tx_done.
        run_burst(2, 8, 2, 0, 1'b0, 1'b1);
        run_burst(2, 8, 2, 0, 1'b1, 1'b0);
        test_async_reset();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
